// File: rtl/e203_reset_seq_if.sv
// Software-reset request and sequenced reset-output bundle of e203_reset_seq.
// master = requester/observer side, slave = the sequencer.
interface e203_reset_seq_if #(
    parameter int N_CH = 4
);
    logic              test_mode;
    logic              sw_rst_all;
    logic [N_CH-1:0]   sw_rst_req;
    logic [N_CH-1:0]   rst_n_o;
    logic              rst_done;
    logic              busy;

    modport master (
        output test_mode, sw_rst_all, sw_rst_req,
        input  rst_n_o, rst_done, busy
    );

    modport slave (
        input  test_mode, sw_rst_all, sw_rst_req,
        output rst_n_o, rst_done, busy
    );
endinterface

// File: rtl/e203_reset_seq.sv
// Reset sequencer: synchronises rst_n, releases N_CH reset domains one by one
// with a programmable gap, and generates global / per-channel software resets.
//
// state | meaning
// RST   | all channels held; waits for srst_n (or a global sw pulse to expire)
// GAP   | counting down the inter-release gap
// REL   | channel idx just released; advance idx or finish
// DONE  | steady state; software requests accepted here only
module e203_reset_seq #(
    parameter int RST_SYNC_LEVEL = 2,
    parameter int N_CH           = 4,
    parameter int GAP            = 3,
    parameter int SW_PULSE       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    e203_reset_seq_if.slave   rs
);
    localparam int GW    = $clog2(GAP + 1);
    localparam int SW_W  = $clog2(SW_PULSE + 1);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {ST_RST, ST_GAP, ST_REL, ST_DONE} state_t;

    logic [RST_SYNC_LEVEL-1:0] sync_q, sync_d;
    state_t                    state_q, state_d;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic [SW_W-1:0]           all_cnt_q, all_cnt_d;
    logic [SW_W-1:0]           ch_cnt_q [N_CH];
    logic [SW_W-1:0]           ch_cnt_d [N_CH];
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_CH-1:0]           out_q, out_d;
    logic                      done_q, done_d;

    logic                      srst_n;
    logic                      all_acc;
    logic [N_CH-1:0]           req_acc;
    logic                      pulse_busy;

    assign srst_n = sync_q[RST_SYNC_LEVEL-1];

    always_comb begin
        sync_d     = {sync_q[RST_SYNC_LEVEL-2:0], 1'b1};
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        all_cnt_d  = all_cnt_q;
        idx_d      = idx_q;
        out_d      = out_q;
        pulse_busy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            ch_cnt_d[i] = ch_cnt_q[i];
        end

        // sw_rst_all has priority over any per-channel request in the same cycle
        all_acc = (state_q == ST_DONE) && rs.sw_rst_all;
        req_acc = ((state_q == ST_DONE) && !rs.sw_rst_all) ? rs.sw_rst_req : '0;

        for (int i = 0; i < N_CH; i++) begin
            if (ch_cnt_q[i] != '0) begin
                pulse_busy = 1'b1;
            end
            if (req_acc[i]) begin
                ch_cnt_d[i] = SW_W'(SW_PULSE);
                out_d[i]    = 1'b0;
            end else if (ch_cnt_q[i] != '0) begin
                ch_cnt_d[i] = ch_cnt_q[i] - SW_W'(1);
                if (ch_cnt_q[i] == SW_W'(1)) begin
                    out_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            ST_RST: begin
                if (all_cnt_q != '0) begin
                    all_cnt_d = all_cnt_q - SW_W'(1);
                end else if (srst_n) begin
                    gap_cnt_d = GW'(GAP - 1);
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // release is registered on the same edge that leaves GAP
                if (gap_cnt_q == '0) begin
                    out_d[idx_q] = 1'b1;
                    state_d      = ST_REL;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            ST_REL: begin
                if (idx_q == IDX_W'(N_CH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    gap_cnt_d = GW'(GAP - 1);
                    state_d   = ST_GAP;
                end
            end
            ST_DONE: begin
                if (all_acc) begin
                    state_d   = ST_RST;
                    all_cnt_d = SW_W'(SW_PULSE);
                    idx_d     = '0;
                    out_d     = '0;
                    for (int i = 0; i < N_CH; i++) begin
                        ch_cnt_d[i] = '0;
                    end
                end
            end
            default: state_d = ST_RST;
        endcase

        // done rises one edge after the last per-channel pulse has ended
        done_d = (state_d == ST_DONE) && !pulse_busy && (req_acc == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= ST_RST;
            gap_cnt_q <= '0;
            all_cnt_q <= '0;
            idx_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ch_cnt_q[i] <= '0;
            end
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            all_cnt_q <= all_cnt_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            done_q    <= done_d;
            for (int i = 0; i < N_CH; i++) begin
                ch_cnt_q[i] <= ch_cnt_d[i];
            end
        end
    end

    assign rs.rst_n_o  = rs.test_mode ? {N_CH{rst_n}} : out_q;
    assign rs.rst_done = done_q;
    assign rs.busy     = ~done_q;
endmodule

// File: tb/tb_e203_reset_seq.sv
// Scoreboard bench for e203_reset_seq: default config plus a 1-channel,
// GAP=1, 3-stage synchroniser instance.
module tb_e203_reset_seq;
    localparam int T_N    = 4;
    localparam int T_GAP  = 3;
    localparam int T_SYNC = 2;
    localparam int T_SW   = 8;

    typedef struct {
        int         tag;
        logic [3:0] o;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_n0;
    logic rst_n1;
    exp_t exp_q[$];
    int   vec;
    int   miss;

    e203_reset_seq_if #(.N_CH(4)) if0 ();
    e203_reset_seq_if #(.N_CH(1)) if1 ();

    e203_reset_seq #(.RST_SYNC_LEVEL(2), .N_CH(4), .GAP(3), .SW_PULSE(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .rs    (if0.slave)
    );

    e203_reset_seq #(.RST_SYNC_LEVEL(3), .N_CH(1), .GAP(1), .SW_PULSE(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .rs    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, wanted $finish earlier");
        $fatal(1);
    end

    // Release schedule for the default config, e edges after the reference point.
    function automatic exp_t seq_exp(input int tag, input int e, input int base);
        exp_t r;
        r.tag = tag;
        for (int k = 0; k < T_N; k++) begin
            r.o[k] = (e >= base + (k + 1) * (T_GAP + 1));
        end
        r.done = (e >= base + T_N * (T_GAP + 1) + 1);
        return r;
    endfunction

    task automatic test_reset();
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        if0.test_mode = 1'b0; if0.sw_rst_all = 1'b0; if0.sw_rst_req = '0;
        if1.test_mode = 1'b0; if1.sw_rst_all = 1'b0; if1.sw_rst_req = '0;
        repeat (3) begin @(posedge clk); #1; end
        vec++;
        if (if0.rst_n_o !== 4'b0000 || if0.rst_done !== 1'b0 || if0.busy !== 1'b1) begin
            miss++;
            $display("FAIL reset0: rst_n_o=%b done=%b busy=%b, want 0000 0 1", if0.rst_n_o, if0.rst_done, if0.busy);
        end
        vec++;
        if (if1.rst_n_o !== 1'b0 || if1.rst_done !== 1'b0 || if1.busy !== 1'b1) begin
            miss++;
            $display("FAIL reset1: rst_n_o=%b done=%b busy=%b, want 0 0 1", if1.rst_n_o, if1.rst_done, if1.busy);
        end
    endtask

    task automatic test_power_on(input bit inject);
        exp_t it;
        rst_n0 = 1'b0;
        @(posedge clk); #1;
        for (int e = 1; e <= 22; e++) exp_q.push_back(seq_exp(e, e, T_SYNC));
        rst_n0 = 1'b1;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (inject && (it.tag inside {3, 7, 12, 18, 19})) begin
                if0.sw_rst_req = 4'($urandom_range(1, 15));
                if0.sw_rst_all = (it.tag == 12);
            end
            @(posedge clk); #1;
            if0.sw_rst_req = '0;
            if0.sw_rst_all = 1'b0;
            vec++;
            if (if0.rst_n_o !== it.o || if0.rst_done !== it.done || if0.busy !== ~it.done) begin
                miss++;
                $display("FAIL power_on(inj=%0d) E%0d: rst_n_o=%b done=%b busy=%b, want %b %b %b",
                         inject, it.tag, if0.rst_n_o, if0.rst_done, if0.busy, it.o, it.done, ~it.done);
            end
        end
    endtask

    task automatic test_sw_req();
        exp_t it;
        for (int t = 0; t <= 11; t++) begin
            it.tag  = t;
            it.o    = (t < T_SW) ? 4'b1011 : 4'b1111;
            it.done = (t >= T_SW + 1);
            exp_q.push_back(it);
        end
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (it.tag == 0) if0.sw_rst_req = 4'b0100;
            @(posedge clk); #1;
            if0.sw_rst_req = '0;
            vec++;
            if (if0.rst_n_o !== it.o || if0.rst_done !== it.done || if0.busy !== ~it.done) begin
                miss++;
                $display("FAIL sw_req S+%0d: rst_n_o=%b done=%b busy=%b, want %b %b %b",
                         it.tag, if0.rst_n_o, if0.rst_done, if0.busy, it.o, it.done, ~it.done);
            end
        end
    endtask

    // ch0 requested at S and again at S+3 (extends), ch3 requested at S+1
    task automatic test_sw_extend();
        exp_t it;
        for (int t = 0; t <= 13; t++) begin
            it.tag  = t;
            it.o    = 4'b1111;
            it.o[0] = !(t < 3 + T_SW);
            it.o[3] = !(t >= 1 && t < 1 + T_SW);
            it.done = (t >= 3 + T_SW + 1);
            exp_q.push_back(it);
        end
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (it.tag == 0 || it.tag == 3) if0.sw_rst_req = 4'b0001;
            if (it.tag == 1) if0.sw_rst_req = 4'b1000;
            @(posedge clk); #1;
            if0.sw_rst_req = '0;
            vec++;
            if (if0.rst_n_o !== it.o || if0.rst_done !== it.done) begin
                miss++;
                $display("FAIL sw_extend S+%0d: rst_n_o=%b done=%b, want %b %b",
                         it.tag, if0.rst_n_o, if0.rst_done, it.o, it.done);
            end
        end
    endtask

    // ch1 pulse in flight, then sw_rst_all + ch0 request two edges later
    task automatic test_sw_all();
        exp_t it;
        for (int t = 0; t <= 29; t++) begin
            if (t < 2) begin
                it.tag  = t;
                it.o    = 4'b1101;
                it.done = 1'b0;
            end else begin
                it = seq_exp(t, t, T_SW + 2);
            end
            exp_q.push_back(it);
        end
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (it.tag == 0) if0.sw_rst_req = 4'b0010;
            if (it.tag == 2) begin
                if0.sw_rst_all = 1'b1;
                if0.sw_rst_req = 4'b0001;
            end
            @(posedge clk); #1;
            if0.sw_rst_req = '0;
            if0.sw_rst_all = 1'b0;
            vec++;
            if (if0.rst_n_o !== it.o || if0.rst_done !== it.done) begin
                miss++;
                $display("FAIL sw_all t%0d: rst_n_o=%b done=%b, want %b %b",
                         it.tag, if0.rst_n_o, if0.rst_done, it.o, it.done);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t it;
        rst_n0 = 1'b0;
        @(posedge clk); #1;
        for (int e = 1; e <= 12; e++) exp_q.push_back(seq_exp(e, e, T_SYNC));
        rst_n0 = 1'b1;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            @(posedge clk); #1;
            vec++;
            if (if0.rst_n_o !== it.o || if0.rst_done !== it.done) begin
                miss++;
                $display("FAIL mid_reset E%0d: rst_n_o=%b done=%b, want %b %b",
                         it.tag, if0.rst_n_o, if0.rst_done, it.o, it.done);
            end
        end
        #3;
        rst_n0 = 1'b0;
        #1;
        vec++;
        if (if0.rst_n_o !== 4'b0000 || if0.rst_done !== 1'b0 || if0.busy !== 1'b1) begin
            miss++;
            $display("FAIL mid_reset async: rst_n_o=%b done=%b busy=%b, want 0000 0 1",
                     if0.rst_n_o, if0.rst_done, if0.busy);
        end
        test_power_on(1'b0);
    endtask

    task automatic test_test_mode();
        exp_t it;
        if0.test_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #($urandom_range(1, 13));
            rst_n0 = ~rst_n0;
            #1;
            vec++;
            if (if0.rst_n_o !== {4{rst_n0}}) begin
                miss++;
                $display("FAIL test_mode toggle%0d: rst_n_o=%b, want %b", i, if0.rst_n_o, {4{rst_n0}});
            end
        end
        @(negedge clk);
        rst_n0 = 1'b0;
        #2;
        vec++;
        if (if0.rst_n_o !== 4'b0000) begin
            miss++;
            $display("FAIL test_mode low: rst_n_o=%b, want 0000", if0.rst_n_o);
        end
        rst_n0 = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            it = seq_exp(e, e, T_SYNC);
            it.o = 4'b1111;
            exp_q.push_back(it);
        end
        #1;
        vec++;
        if (if0.rst_n_o !== 4'b1111) begin
            miss++;
            $display("FAIL test_mode high: rst_n_o=%b, want 1111", if0.rst_n_o);
        end
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            @(posedge clk); #1;
            vec++;
            if (if0.rst_n_o !== it.o || if0.rst_done !== it.done) begin
                miss++;
                $display("FAIL test_mode run E%0d: rst_n_o=%b done=%b, want %b %b",
                         it.tag, if0.rst_n_o, if0.rst_done, it.o, it.done);
            end
        end
        if0.test_mode = 1'b0;
        #1;
        vec++;
        if (if0.rst_n_o !== 4'b1111 || if0.rst_done !== 1'b1) begin
            miss++;
            $display("FAIL test_mode exit: rst_n_o=%b done=%b, want 1111 1", if0.rst_n_o, if0.rst_done);
        end
    endtask

    task automatic test_small_config();
        exp_t it;
        rst_n1 = 1'b0;
        @(posedge clk); #1;
        for (int e = 1; e <= 8; e++) begin
            it.tag  = e;
            it.o    = {3'b000, (e >= 5)};
            it.done = (e >= 6);
            exp_q.push_back(it);
        end
        rst_n1 = 1'b1;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (it.tag inside {3, 4, 5, 6}) begin
                if1.sw_rst_req = 1'b1;
                if1.sw_rst_all = (it.tag == 4);
            end
            @(posedge clk); #1;
            if1.sw_rst_req = '0;
            if1.sw_rst_all = 1'b0;
            vec++;
            if (if1.rst_n_o !== it.o[0:0] || if1.rst_done !== it.done || if1.busy !== ~it.done) begin
                miss++;
                $display("FAIL small_cfg E%0d: rst_n_o=%b done=%b busy=%b, want %b %b %b",
                         it.tag, if1.rst_n_o, if1.rst_done, if1.busy, it.o[0], it.done, ~it.done);
            end
        end
    endtask

    initial begin
        vec  = 0;
        miss = 0;
        test_reset();
        test_power_on(1'b0);
        test_sw_req();
        test_sw_extend();
        test_sw_all();
        test_mid_reset();
        test_test_mode();
        test_power_on(1'b1);
        test_small_config();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/e203_reset_seq.md
# e203_reset_seq

Parametrised reset sequencer that supersedes the single-output reset synchroniser. It synchronises the external asynchronous reset and releases `N_CH` downstream reset domains one at a time with a programmable gap. It also provides per-channel and global software-reset pulses and a DFT `test_mode` bypass. It sits between the SoC reset pin and the core, bus and peripheral subsystems, all in the single `clk` domain.

## Interface
- `RST_SYNC_LEVEL`, default 2: synchroniser flop count on reset deassertion, minimum 2.
- `N_CH`, default 4: number of reset output channels, 1..16.
- `GAP`, default 3: cycles between successive channel releases, minimum 1.
- `SW_PULSE`, default 8: length in cycles of a software reset pulse, minimum 1.

- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low; assertion acts immediately, deassertion is synchronised.
- `test_mode`  in  1  DFT bypass; when 1, every `rst_n_o` bit equals `rst_n` combinationally.
- `sw_rst_all`  in  1  single-cycle request: global software reset and re-sequence.
- `sw_rst_req`  in  N_CH  per-channel single-cycle software reset requests.
- `rst_n_o`  out  N_CH  active-low reset per channel; bit 0 is released first.
- `rst_done`  out  1  all channels released and no software pulse active.
- `busy`  out  1  equals ~rst_done.

## Operation
- Synchroniser: a chain of `RST_SYNC_LEVEL` flops, async-cleared by `rst_n`, shifting in 1. `srst_n` is the last stage.
- FSM states: RST, GAP, REL, DONE.
  - RST: all outputs low, `idx`=0. When `srst_n`=1, load `cnt`=GAP-1 and go to GAP.
  - GAP: decrement `cnt`. At `cnt`=0 go to REL.
  - REL: set `rst_n_o[idx]`=1. If `idx`=N_CH-1 go to DONE; otherwise `idx`++, reload `cnt`, go to GAP.
  - DONE: steady state. Software requests are honoured only here.
- `sw_rst_all` in DONE: all channels go low at the next edge and are held for SW_PULSE cycles (shared counter). After that, go to GAP with `idx`=0 and re-sequence exactly as after power-on. No synchroniser involvement.
- `sw_rst_req[i]` in DONE: channel i goes low at the next edge and is held for SW_PULSE cycles (per-channel counter). It then returns high with no re-sequencing. Other channels are unaffected.
- A repeat request on a channel already pulsing reloads its counter, which extends the pulse.
- `sw_rst_all` and any `sw_rst_req` in the same cycle: `sw_rst_all` wins and per-channel counters are cleared.
- Software requests outside DONE are dropped, with no queueing.
- `rst_done`=1 only in DONE with no per-channel pulse active.
- `rst_n` assertion at any time, mid-sequence or mid-pulse: all flops clear asynchronously, all outputs go low in the same instant, and the FSM returns to RST.
- `test_mode`=1 only affects the output mux. FSM, counters and `rst_done` keep running.
- Counter widths: `$clog2(GAP+1)`, `$clog2(SW_PULSE+1)`, `$clog2(N_CH)` (minimum 1).

## Timing
- Reset values: `rst_n_o`=0 on all bits, `rst_done`=0, `busy`=1, FSM=RST, all counters 0.
- All outputs are registered, except the `test_mode` mux path.
- Edges are numbered from the first posedge after `rst_n` rises, as E1.
  - `srst_n`=1 after E[RST_SYNC_LEVEL].
  - `rst_n_o[k]` rises after E[RST_SYNC_LEVEL + (k+1)·(GAP+1)].
  - `rst_done` rises one edge after the last channel rises.
- Defaults give: ch0 after E6, ch1 after E10, ch2 after E14, ch3 after E18, `rst_done` after E19.
- Software request sampled at edge S:
  - channel low after S.
  - channel high after S+SW_PULSE.
  - for `sw_rst_all`, ch0 high after S+SW_PULSE+GAP+1.
- `rst_done` falls after S and rises one edge after the last affected channel rises.

## Test plan
- Power-on with defaults: release `rst_n` → `rst_n_o` goes 0001, 0011, 0111, 1111 after E6, E10, E14, E18; `rst_done`=1 after E19.
- `rst_n` asserted mid-sequence, after E12 (`rst_n_o`=0011) → `rst_n_o`=0000 and `rst_done`=0 immediately, without a clock. Re-release repeats the E6…E19 sequence.
- In DONE, pulse `sw_rst_req`=0100 at S → bit 2 low for 8 cycles, others stay 1. `rst_done` low over the same window.
- In DONE, pulse `sw_rst_all` and `sw_rst_req`=0001 in the same cycle → all channels low for 8 cycles. Then re-sequence with ch0 high after S+12, ch3 after S+24.
- `test_mode`=1 while toggling `rst_n` at arbitrary times → `rst_n_o` equals `{N_CH{rst_n}}` combinationally. With `test_mode`=0, sequenced values return.
- `sw_rst_req` issued during sequencing (before DONE) → ignored, and the release schedule is unchanged. Repeat with N_CH=1, GAP=1, RST_SYNC_LEVEL=3 → ch0 high after E5, `rst_done` after E6.
